// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage and the decoder it feeds.
// Opcode values match the encodings that maindecoder switches on.
package instr_fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_ITYPE  = 7'b0010011,
      OP_STORE  = 7'b0100011,
      OP_RTYPE  = 7'b0110011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111
   } opcode_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small power-of-two FIFO used for the instruction buffer and the pending-PC queue.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CNTW-1:0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CNTW-1:0]  occ;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage carries no reset; the occupancy count decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign empty     = (occ == '0);
   assign full      = (occ == CNTW'(DEPTH));
   assign count     = occ;
   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word fetches, pairs in-order responses with their PC,
// buffers them for the decoder and handles taken-branch redirects.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        pcsrc,
   input  logic [31:0] branch_target
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic            started;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   pend_count;
   logic [CW-1:0]   buf_count;
   logic [CW:0]     in_use;
   logic            pend_empty;
   logic            pend_full;
   logic            buf_empty;
   logic            buf_full;
   logic [XLEN-1:0] pend_head;
   fetch_entry_t    buf_in;
   fetch_entry_t    buf_head;
   logic            req_fire;
   logic            rsp_live;
   logic            rsp_take;
   logic            dec_fire;

   // Requests are credit-limited so every response always finds a buffer slot.
   assign in_use         = {1'b0, pend_count} + {1'b0, buf_count};
   assign imem_req_valid = started && (drop_cnt == '0) && !pcsrc && !pend_full && !buf_full
                           && (in_use < (CW+1)'(BUF_DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_live = imem_rsp_valid && started && ((drop_cnt != '0) || !pend_empty);
   assign rsp_take = rsp_live && (drop_cnt == '0) && !pcsrc;
   assign buf_in   = '{pc: pend_head, instr: imem_rsp_data};

   assign dec_valid = !buf_empty;
   assign dec_fire  = dec_valid && dec_ready;
   assign dec_instr = buf_empty ? '0 : buf_head.instr;
   assign dec_pc    = buf_empty ? '0 : buf_head.pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= align_word(RESET_PC);
         started  <= 1'b0;
      end else begin
         started <= 1'b1;
         if (pcsrc)         fetch_pc <= align_word(branch_target);
         else if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // On redirect, everything still in flight becomes stale; a response arriving
   // in the redirect cycle itself is discarded there and not counted again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (pcsrc) begin
         drop_cnt <= drop_cnt + pend_count - CW'(rsp_live);
      end else if (rsp_live && (drop_cnt != '0)) begin
         drop_cnt <= drop_cnt - 1'b1;
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (XLEN),
      .CNTW  (CW)
   ) u_pend_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (rsp_take),
      .flush     (pcsrc),
      .head_data (pend_head),
      .full      (pend_full),
      .empty     (pend_empty),
      .count     (pend_count)
   );

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(fetch_entry_t)),
      .CNTW  (CW)
   ) u_instr_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_take),
      .push_data (buf_in),
      .pop       (dec_fire),
      .flush     (pcsrc),
      .head_data (buf_head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a queue-based memory model answers fetches,
// and a monitor checks every decoder handshake against the expected program stream.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        pcsrc;
   logic [31:0] branch_target;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .pcsrc          (pcsrc),
      .branch_target  (branch_target)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] memQ[$];
   int          memDue[$];
   logic [31:0] expQ[$];
   logic [31:0] modelPc = RESET_PC;
   int          cycleNo = 0;
   int          lastDue = 0;
   int          fixedLat = 1;
   int          acceptCount = 0;
   logic        lastReqValid;
   logic [31:0] lastReqAddr;

   // Program memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   // One clock cycle: drive at the falling edge, observe, then update the models.
   task automatic applyStimulus(input logic rdy, input logic drdy, input logic br, input logic [31:0] tgt);
      logic rspNow;
      int   lat;
      int   due;
      @(negedge clk);
      imem_req_ready = rdy;
      dec_ready      = drdy;
      pcsrc          = br;
      branch_target  = tgt;
      rspNow = (memQ.size() > 0) && (memDue[0] <= cycleNo);
      imem_rsp_valid = rspNow;
      if (rspNow) imem_rsp_data = memWord(memQ[0]);
      else        imem_rsp_data = $urandom;
      #1;
      lastReqValid = imem_req_valid;
      lastReqAddr  = imem_req_addr;
      if (br) checkOutput("req_during_redirect", {31'd0, imem_req_valid}, 32'd0);
      #2;
      if (rspNow) begin
         void'(memQ.pop_front());
         void'(memDue.pop_front());
      end
      if (lastReqValid && rdy) begin
         checkOutput("req_addr", lastReqAddr, modelPc);
         lat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 3));
         due = (cycleNo + lat > lastDue) ? cycleNo + lat : lastDue + 1;
         lastDue = due;
         memQ.push_back(lastReqAddr);
         memDue.push_back(due);
         expQ.push_back(modelPc);
         modelPc = modelPc + 32'd4;
         acceptCount++;
      end
      if (br) begin
         expQ.delete();
         modelPc = tgt & ~32'h3;
      end
      cycleNo++;
   endtask

   task automatic drain();
      int n = 0;
      while ((memQ.size() > 0 || dec_valid || imem_rsp_valid) && n < 40) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
         n++;
      end
      checkOutput("drain_done", {31'd0, (memQ.size() == 0 && !dec_valid)}, 32'd1);
      checkOutput("no_lost_entries", expQ.size(), 32'd0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
      checkOutput("rst_dec_instr", dec_instr, 32'd0);
      checkOutput("rst_dec_pc", dec_pc, 32'd0);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      dec_ready      = 1'b0;
      pcsrc          = 1'b0;
      branch_target  = 32'd0;
      memQ.delete();
      memDue.delete();
      expQ.delete();
      modelPc = RESET_PC;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      imem_req_ready = 1'b1;
      #1;
      checkOutput("req_valid_first_cycle", {31'd0, imem_req_valid}, 32'd0);
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      checkOutput("req_valid_after_edge", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("req_addr_after_reset", imem_req_addr, RESET_PC);
      lastDue = cycleNo;
   endtask

   // Monitor: every decoder handshake must match the head of the expected stream.
   initial begin
      logic [31:0] expPc;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && dec_valid && dec_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL dec_unexpected actual_pc=%h required=none", dec_pc);
            end else begin
               expPc = expQ.pop_front();
               checkOutput("dec_pc", dec_pc, expPc);
               checkOutput("dec_instr", dec_instr, memWord(expPc));
            end
         end
      end
   end

   initial begin
      int          base;
      logic [31:0] holdAddr;
      doReset();

      $display("[TB] sequential stream from reset");
      fixedLat = 1;
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      drain();

      $display("[TB] decoder stall");
      base = acceptCount;
      repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("stall_accepts", acceptCount - base, BUF_DEPTH);
      checkOutput("stall_req_valid", {31'd0, lastReqValid}, 32'd0);
      checkOutput("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
      drain();

      $display("[TB] request held without ready");
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      holdAddr = lastReqAddr;
      checkOutput("hold_req_valid", {31'd0, lastReqValid}, 32'd1);
      base = acceptCount;
      repeat (2) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
         checkOutput("hold_addr", lastReqAddr, holdAddr);
         checkOutput("hold_req_valid", {31'd0, lastReqValid}, 32'd1);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("hold_single_accept", acceptCount - base, 32'd1);
      drain();

      $display("[TB] redirect with two outstanding");
      fixedLat = 3;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("outstanding_before_redirect", memQ.size(), 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      fixedLat = 1;
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      drain();

      $display("[TB] address wrap");
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      drain();

      $display("[TB] random traffic");
      fixedLat = 0;
      repeat (400) applyStimulus($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 25 == 0, $urandom);
      drain();

      $display("[TB] reset mid-stream");
      fixedLat = 3;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      #4;
      doReset();
      fixedLat = 1;
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
